stack_feeder: RTL and testbench

- Write-side controller for the dual-stack register array (`stack_top`).
- Accepts a valid/ready stream of pixel pairs and drives the array's `en`, `col`, `buf_in1` and `buf_in2` for a COLS x ROWS feature map, one pair per column.
- After the last row it pushes one zero row so the final row reaches the stack outputs, then pulses `frame_done`.
- Sits between the layer input buffer and `stack_top` inside CCM.

---
 rtl/ccm_pkg.sv | 14 +
 rtl/col_row_counter.sv | 36 +++
 rtl/stack_feeder.sv | 129 ++++++++++++
 tb/tb_stack_feeder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_pkg.sv
// Shared CCM definitions: feeder state encoding and common widths.
package ccm_pkg;

  localparam int COL_W      = 9;
  localparam int DEFAULT_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/col_row_counter.sv
// Column counter that wraps at COLS and carries into a row counter.
module col_row_counter
  import ccm_pkg::*;
#(
  parameter int COLS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [COL_W-1:0] col_cnt,
  output logic [COL_W-1:0] row_cnt,
  output logic             col_last
);

  assign col_last = (col_cnt == COL_W'(COLS - 1));

  // Clear wins over increment so a restart never inherits a stale position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (inc) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + COL_W'(1);
      end else begin
        col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/stack_feeder.sv
// Write-side controller for the dual-stack array: streams pixel pairs into
// the stacks column by column, then pushes one zero row to flush the last row.
module stack_feeder
  import ccm_pkg::*;
#(
  parameter int COLS = 256,
  parameter int ROWS = 256,
  parameter int DW   = DEFAULT_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data1,
  input  logic [DW-1:0]    in_data2,
  output logic             en,
  output logic [COL_W-1:0] col,
  output logic [DW-1:0]    buf_in1,
  output logic [DW-1:0]    buf_in2,
  output logic             prev_valid,
  output logic [COL_W-1:0] row,
  output logic             busy,
  output logic             frame_done
);

  state_t           state_q;
  state_t           state_d;
  logic             cnt_clear;
  logic             cnt_inc;
  logic [COL_W-1:0] col_cnt;
  logic [COL_W-1:0] row_cnt;
  logic             col_last;
  logic             accept;

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid && in_ready;

  col_row_counter #(.COLS(COLS)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .col_cnt  (col_cnt),
    .row_cnt  (row_cnt),
    .col_last (col_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The last accepted column wraps the counter to zero, so FLUSH starts at col 0.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_RUN;
            cnt_clear = 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cnt_inc = 1'b1;
            if (col_last && (row_cnt == COL_W'(ROWS - 1))) state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          cnt_inc = 1'b1;
          if (col_last) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes default low each cycle; col/row/buf_in hold between pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en         <= 1'b0;
      col        <= '0;
      row        <= '0;
      buf_in1    <= '0;
      buf_in2    <= '0;
      prev_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      en         <= 1'b0;
      prev_valid <= 1'b0;
      frame_done <= 1'b0;
      if (!abort) begin
        case (state_q)
          ST_RUN: begin
            if (accept) begin
              en         <= 1'b1;
              col        <= col_cnt;
              row        <= row_cnt;
              buf_in1    <= in_data1;
              buf_in2    <= in_data2;
              prev_valid <= (row_cnt != '0);
            end
          end
          ST_FLUSH: begin
            en         <= 1'b1;
            col        <= col_cnt;
            row        <= COL_W'(ROWS);
            buf_in1    <= '0;
            buf_in2    <= '0;
            prev_valid <= 1'b1;
          end
          ST_DONE: frame_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_feeder.sv
// Randomized and directed bench for stack_feeder against a count-based frame model.
module tb_stack_feeder;

  localparam int C  = 4;
  localparam int R  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, in_valid;
  logic [DW-1:0] in_data1, in_data2;
  logic          in_ready, en, prev_valid, busy, frame_done;
  logic [8:0]    col, row;
  logic [DW-1:0] buf_in1, buf_in2;

  logic          s1_start, s1_abort, s1_valid;
  logic [DW-1:0] s1_d1, s1_d2;
  logic          s1_ready, s1_en, s1_pv, s1_busy, s1_fd;
  logic [8:0]    s1_col, s1_row;
  logic [DW-1:0] s1_b1, s1_b2;

  int checks = 0;
  int errors = 0;

  // Model: frame progress expressed as pairs accepted and flush pushes issued.
  int            m_phase;
  int            m_n;
  int            m_f;
  logic          exp_en, exp_pv, exp_fd;
  logic [8:0]    exp_col, exp_row;
  logic [DW-1:0] exp_b1, exp_b2;

  always #5 clk = ~clk;

  stack_feeder #(.COLS(C), .ROWS(R), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2),
    .en(en), .col(col), .buf_in1(buf_in1), .buf_in2(buf_in2),
    .prev_valid(prev_valid), .row(row), .busy(busy), .frame_done(frame_done)
  );

  stack_feeder #(.COLS(1), .ROWS(1), .DW(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort),
    .in_valid(s1_valid), .in_ready(s1_ready),
    .in_data1(s1_d1), .in_data2(s1_d2),
    .en(s1_en), .col(s1_col), .buf_in1(s1_b1), .buf_in2(s1_b2),
    .prev_valid(s1_pv), .row(s1_row), .busy(s1_busy), .frame_done(s1_fd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    check("en", 32'(en), 32'(exp_en));
    check("col", 32'(col), 32'(exp_col));
    check("row", 32'(row), 32'(exp_row));
    check("buf_in1", 32'(buf_in1), 32'(exp_b1));
    check("buf_in2", 32'(buf_in2), 32'(exp_b2));
    check("prev_valid", 32'(prev_valid), 32'(exp_pv));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("in_ready_post", 32'(in_ready), 32'(m_phase == 1));
  endtask

  task automatic modelReset();
    m_phase = 0; m_n = 0; m_f = 0;
    exp_en = 0; exp_pv = 0; exp_fd = 0;
    exp_col = '0; exp_row = '0; exp_b1 = '0; exp_b2 = '0;
  endtask

  // Called at a falling edge: drive inputs, predict the next edge, check after it.
  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [DW-1:0] x1, input logic [DW-1:0] x2);
    start = s; abort = a; in_valid = v; in_data1 = x1; in_data2 = x2;
    #1;
    check("in_ready", 32'(in_ready), 32'(m_phase == 1));
    exp_en = 0; exp_pv = 0; exp_fd = 0;
    if (a) begin
      m_phase = 0; m_n = 0; m_f = 0;
    end else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_n = 0; end
        1: if (v) begin
          exp_en = 1; exp_col = 9'(m_n % C); exp_row = 9'(m_n / C);
          exp_b1 = x1; exp_b2 = x2; exp_pv = (m_n >= C);
          m_n++;
          if (m_n == C * R) begin m_phase = 2; m_f = 0; end
        end
        2: begin
          exp_en = 1; exp_col = 9'(m_f); exp_row = 9'(R);
          exp_b1 = '0; exp_b2 = '0; exp_pv = 1;
          m_f++;
          if (m_f == C) m_phase = 3;
        end
        default: begin m_phase = 0; exp_fd = 1; end
      endcase
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * C + 8; k++) begin
      if (m_phase == 0) break;
      applyStimulus(0, 0, 0, 8'($urandom), 8'($urandom));
    end
    check("drain_idle", 32'(m_phase), 32'(0));
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_en"}, 32'(en), 0);
    check({tag, "_col"}, 32'(col), 0);
    check({tag, "_row"}, 32'(row), 0);
    check({tag, "_buf1"}, 32'(buf_in1), 0);
    check({tag, "_buf2"}, 32'(buf_in2), 0);
    check({tag, "_pv"}, 32'(prev_valid), 0);
    check({tag, "_fd"}, 32'(frame_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; in_valid = 0; in_data1 = 0; in_data2 = 0;
    s1_start = 0; s1_abort = 0; s1_valid = 0; s1_d1 = 0; s1_d2 = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkZero("reset");
    rst_n = 1;

    // in_valid without start is ignored
    applyStimulus(0, 0, 1, 8'd55, 8'd66);

    // Full frame, in_valid held, pairs (i, 100+i)
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 1, 8'(i), 8'(100 + i));
    drain();

    // Alternating valid
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 2 * C * R; i++)
      applyStimulus(0, 0, 1'(i % 2 == 0), 8'($urandom), 8'($urandom));
    drain();

    // Abort after three accepts, then restart with random valid and stray starts
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'($urandom), 8'($urandom));
    applyStimulus(0, 1, 1, 8'($urandom), 8'($urandom));
    applyStimulus(1, 0, 1, 8'($urandom), 8'($urandom));
    for (int k = 0; k < 200 && m_phase != 0; k++)
      applyStimulus(1'($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom));
    drain();

    // Random frames with rare aborts
    for (int fr = 0; fr < 4; fr++) begin
      applyStimulus(1, 0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      for (int k = 0; k < 200 && m_phase != 0; k++)
        applyStimulus(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 60) == 0),
                      1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom));
      drain();
    end

    // COLS=1, ROWS=1 instance
    s1_start = 1; @(negedge clk);
    s1_start = 0; s1_valid = 1; s1_d1 = 8'd7; s1_d2 = 8'd9;
    #1 check("c1_ready", 32'(s1_ready), 1);
    @(negedge clk);
    s1_valid = 0;
    check("c1_push_en", 32'(s1_en), 1);
    check("c1_push_col", 32'(s1_col), 0);
    check("c1_push_row", 32'(s1_row), 0);
    check("c1_push_b1", 32'(s1_b1), 7);
    check("c1_push_b2", 32'(s1_b2), 9);
    check("c1_push_pv", 32'(s1_pv), 0);
    @(negedge clk);
    check("c1_flush_en", 32'(s1_en), 1);
    check("c1_flush_col", 32'(s1_col), 0);
    check("c1_flush_row", 32'(s1_row), 1);
    check("c1_flush_b1", 32'(s1_b1), 0);
    check("c1_flush_pv", 32'(s1_pv), 1);
    check("c1_flush_fd", 32'(s1_fd), 0);
    @(negedge clk);
    check("c1_done_fd", 32'(s1_fd), 1);
    check("c1_done_en", 32'(s1_en), 0);
    @(negedge clk);
    check("c1_after_fd", 32'(s1_fd), 0);
    check("c1_after_busy", 32'(s1_busy), 0);

    // Reset mid-RUN after five accepts
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    rst_n = 0;
    #1;
    checkZero("midreset");
    check("midreset_ready", 32'(in_ready), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1;
    applyStimulus(0, 0, 1, 8'd11, 8'd22);
    applyStimulus(0, 0, 1, 8'd33, 8'd44);
    applyStimulus(1, 0, 1, 8'd1, 8'd2);
    for (int k = 0; k < 200 && m_phase != 0; k++)
      applyStimulus(0, 0, 1, 8'($urandom), 8'($urandom));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
